// File: rtl/trap_pkg.sv
// trap_pkg: op/state encodings, machine-mode CSR addresses and cause codes shared by trap_ctrl.
package trap_pkg;
   typedef enum logic [2:0] {
      OP_ECALL = 3'd0,
      OP_MRET  = 3'd1,
      OP_CSRRW = 3'd2,
      OP_CSRRS = 3'd3,
      OP_CSRRC = 3'd4
   } op_t;

   typedef enum logic [2:0] {S_IDLE, S_TRAP, S_REDIR, S_CSR_RD, S_CSR_WR, S_DONE_NOP} state_t;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

   // First busy state for an accepted op; reserved encodings just complete.
   function automatic state_t dispatch(input logic [2:0] op);
      return op == OP_ECALL ? S_TRAP :
             op == OP_MRET  ? S_REDIR :
             (op >= OP_CSRRW && op <= OP_CSRRC) ? S_CSR_RD : S_DONE_NOP;
   endfunction
endpackage

// File: rtl/csr_alu.sv
// csr_alu: new CSR value for CSRRW/CSRRS/CSRRC from the old value and rs1.
module csr_alu
   import trap_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] old,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] wdata
);
   always_comb wdata = op == OP_CSRRS ? old | src : op == OP_CSRRC ? old & ~src : src;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences ECALL/MRET/CSR ops onto the machine-mode CSR file and returns redirect or rd writeback.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_pc,
   input  logic [11:0]     req_csr,
   input  logic [XLEN-1:0] req_src,
   input  logic [4:0]      req_rs1_idx,
   input  logic [4:0]      req_rd_idx,
   output logic [11:0]     csr_raddr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic [11:0]     csr_waddr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_wen,
   output logic [XLEN-1:0] mepc_in,
   output logic            mepc_wen,
   output logic [XLEN-1:0] mcause_in,
   output logic            mcause_wen,
   input  logic [XLEN-1:0] mepc,
   input  logic [XLEN-1:0] mtvec,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   output logic            resp_valid,
   output logic            rd_wen,
   output logic [4:0]      rd_idx,
   output logic [XLEN-1:0] rd_wdata
);
   state_t          state;
   logic [2:0]      op;
   logic [XLEN-1:0] pc, src, old, alu_wdata;
   logic [11:0]     csr;
   logic [4:0]      rs1, rd;
   logic            live, in_trap, in_redir, in_rd, in_wr, in_nop;

   always_ff @(posedge clk)
      if (rst) begin
         state <= S_IDLE;
         op    <= '0;
         pc    <= '0;
         src   <= '0;
         old   <= '0;
         csr   <= '0;
         rs1   <= '0;
         rd    <= '0;
      end else
         case (state)
            S_IDLE: if (req_valid) begin
               state <= dispatch(req_op);
               op    <= req_op;
               pc    <= req_pc;
               csr   <= req_csr;
               src   <= req_src;
               rs1   <= req_rs1_idx;
               rd    <= req_rd_idx;
            end
            S_TRAP: state <= S_REDIR;
            S_CSR_RD: begin
               old   <= csr_rdata;
               state <= S_CSR_WR;
            end
            default: state <= S_IDLE;
         endcase

   csr_alu #(.XLEN(XLEN)) u_alu (
      .op    (op),
      .old   (old),
      .src   (src),
      .wdata (alu_wdata)
   );

   // Every output is masked by rst so a reset cycle never leaks a strobe or stale data.
   always_comb begin
      live        = !rst;
      in_trap     = live && state == S_TRAP;
      in_redir    = live && state == S_REDIR;
      in_rd       = live && state == S_CSR_RD;
      in_wr       = live && state == S_CSR_WR;
      in_nop      = live && state == S_DONE_NOP;
      req_ready   = live && state == S_IDLE;
      csr_raddr   = in_rd ? csr : '0;
      csr_waddr   = in_wr ? csr : '0;
      csr_wdata   = in_wr ? alu_wdata : '0;
      csr_wen     = in_wr && (op == OP_CSRRW || rs1 != '0);
      mepc_wen    = in_trap;
      mepc_in     = in_trap ? pc : '0;
      mcause_wen  = in_trap;
      mcause_in   = in_trap ? ECALL_CAUSE : '0;
      redir_valid = in_redir;
      redir_pc    = in_redir ? (op == OP_ECALL ? mtvec : mepc) : '0;
      resp_valid  = in_redir || in_wr || in_nop;
      rd_wen      = in_wr && rd != '0;
      rd_idx      = in_wr ? rd : '0;
      rd_wdata    = in_wr ? old : '0;
   end
endmodule
